mc_cu: RTL and testbench
========================

MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- inst  in  32  current instruction from IR, stable from ID through WB
- branch  in  2  comparator result: EQ/LT/GT, encodings per shared param.v
- imem_ack  in  1  instruction memory ready
- dmem_ack  in  1  data memory ready
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC update strobe
- pc_sel  out  1  1 = PC source is ALU result (JALR)
- npc_op  out  1  1 = PC+offset, 0 = PC+4
- rf_we  out  1  register-file write strobe
- wd_sel  out  2  write-back source (RF_ALU_C / RF_DRAM_RD / RF_NPC_PC4)
- sext_op  out  3  immediate format (I/S/B/U/J)
- alu_op  out  4  ALU operation (param.v codes)
- alub_sel  out  1  1 = ALU B is immediate
- dram_we  out  1  data memory write enable
- state  out  3  current FSM state
- halted  out  1  FSM in HALT
- instret  out  32  retired-instruction count

Function
REQ-002 SHALL implement a Moore FSM with states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; state 6/7 SHALL go to IF on next edge.
REQ-003 IF: imem_req=1; if imem_ack=1, ir_we=1 in that same cycle and next=ID; else stay in IF.
REQ-004 ID: opcode inst[6:0] in {0110011 R, 0010011 I, 0000011 LW, 0100011 S, 1100011 B, 0110111 LUI, 1101111 JAL, 1100111 JALR} -> EX; any other opcode -> HALT.
REQ-005 EX: B -> pc_we=1, next=IF; LW or S -> next=MEM; all others -> next=WB.
REQ-006 B taken rule in EX: funct3 000 taken iff branch==EQ; 001 iff branch!=EQ; 100 iff branch==LT; 101 iff branch==GT or EQ; other funct3 never taken; npc_op = taken.
REQ-007 MEM: dmem_req=1, dram_we=1 for S only; hold until dmem_ack=1; then S -> pc_we=1, next=IF; LW -> next=WB.
REQ-008 WB: rf_we=1, pc_we=1, next=IF.
REQ-009 HALT: all strobes 0, halted=1, remain until reset.
REQ-010 Decode outputs, valid in ID/EX/MEM/WB, zero in IF/HALT:
- R: alub_sel=0, wd_sel=RF_ALU_C; alu_op from funct3: 000 ADD/SUB by inst[30], 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA by inst[30].
- I: same funct3 map, alub_sel=1, sext_op=I; 101 uses inst[30]; 010 -> ADD.
- LW: ADD, alub_sel=1, sext_op=I, wd_sel=RF_DRAM_RD.
- S: ADD, alub_sel=1, sext_op=S.
- B: SUB, alub_sel=0, sext_op=B.
- LUI: SEL_B, alub_sel=1, sext_op=U, wd_sel=RF_ALU_C.
- JAL: npc_op=1, sext_op=J, wd_sel=RF_NPC_PC4.
- JALR: pc_sel=1, ADD, alub_sel=1, sext_op=I, wd_sel=RF_NPC_PC4.
REQ-011 pc_we, ir_we, rf_we and dram_we SHALL each be high for at most one cycle per instruction; dram_we stays high through the MEM wait.
REQ-012 imem_ack outside IF and dmem_ack outside MEM SHALL be ignored.
REQ-013 instret SHALL increment by 1 on every clock edge where pc_we=1, wrapping 0xFFFFFFFF -> 0.
REQ-014 Latency without memory wait: B = 3 cycles; R/I/LUI/JAL/JALR = 4; S = 4; LW = 5.

Reset
REQ-015 rst_n=0 SHALL asynchronously force state=IF, instret=0, halted=0 and all strobes 0, regardless of current state or pending handshake.
REQ-016 After rst_n deasserts, the first request SHALL be imem_req=1 on the next cycle.

Verification
REQ-017 add x1,x2,x3 (0x003100B3), acks immediate -> IF,ID,EX,WB; rf_we=1 and pc_we=1 in WB only; instret 0->1.
REQ-018 beq (funct3 000), branch=EQ -> pc_we=1, npc_op=1 in EX; branch=LT -> npc_op=0; no rf_we.
REQ-019 lw with dmem_ack held low 3 cycles -> dmem_req high 4 cycles in MEM, then WB with wd_sel=RF_DRAM_RD, rf_we=1.
REQ-020 sw -> dram_we=1 only in MEM, pc_we on the ack cycle, rf_we never 1, next state IF.
REQ-021 opcode 0x7F -> HALT, halted=1, imem_req=0 indefinitely; rst_n pulse -> IF, instret=0.
REQ-022 rst_n asserted mid-MEM while dmem_req=1 -> immediately dmem_req=0, state=IF, instret=0.

Source files
------------

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for an RV32 subset.
// An IF/ID/EX/MEM/WB/HALT Moore FSM with decode outputs and a retired-instruction counter.
module mc_cu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic [1:0]  branch,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        npc_op,
   output logic        rf_we,
   output logic [1:0]  wd_sel,
   output logic [2:0]  sext_op,
   output logic [3:0]  alu_op,
   output logic        alub_sel,
   output logic        dram_we,
   output logic [2:0]  state,
   output logic        halted,
   output logic [31:0] instret
);
   localparam logic [1:0] BR_EQ = 2'd0, BR_LT = 2'd1, BR_GT = 2'd2;
   localparam logic [1:0] RF_ALU_C = 2'd0, RF_DRAM_RD = 2'd1, RF_NPC_PC4 = 2'd2;
   localparam logic [2:0] EXT_I = 3'd1, EXT_S = 3'd2, EXT_B = 3'd3, EXT_U = 3'd4, EXT_J = 3'd5;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                          ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_SEL_B = 4'd8;

   typedef enum logic [2:0] {
      S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
   } state_t;

   state_t st;
   logic   run;

   wire [6:0] opc = inst[6:0];
   wire [2:0] f3  = inst[14:12];
   wire       alt = inst[30];
   logic      unused_inst;
   assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

   wire is_r    = opc == 7'b0110011;
   wire is_i    = opc == 7'b0010011;
   wire is_lw   = opc == 7'b0000011;
   wire is_s    = opc == 7'b0100011;
   wire is_b    = opc == 7'b1100011;
   wire is_lui  = opc == 7'b0110111;
   wire is_jal  = opc == 7'b1101111;
   wire is_jalr = opc == 7'b1100111;
   wire legal   = is_r | is_i | is_lw | is_s | is_b | is_lui | is_jal | is_jalr;

   // Only register ops may turn funct3=000 into SUB; ADDI ignores bit 30.
   function automatic logic [3:0] alu_fn(input logic [2:0] f, input logic a, input logic sub_ok);
      return f == 3'b000 ? ((sub_ok && a) ? ALU_SUB : ALU_ADD) :
             f == 3'b111 ? ALU_AND :
             f == 3'b110 ? ALU_OR  :
             f == 3'b100 ? ALU_XOR :
             f == 3'b001 ? ALU_SLL :
             f == 3'b101 ? (a ? ALU_SRA : ALU_SRL) : ALU_ADD;
   endfunction

   wire taken = f3 == 3'b000 ? branch == BR_EQ :
                f3 == 3'b001 ? branch != BR_EQ :
                f3 == 3'b100 ? branch == BR_LT :
                f3 == 3'b101 ? (branch == BR_GT || branch == BR_EQ) : 1'b0;

   wire dv = st == S_ID || st == S_EX || st == S_MEM || st == S_WB;

   assign alu_op   = !dv ? 4'd0 : is_r ? alu_fn(f3, alt, 1'b1) : is_i ? alu_fn(f3, alt, 1'b0) :
                     is_b ? ALU_SUB : is_lui ? ALU_SEL_B : ALU_ADD;
   assign alub_sel = dv && (is_i || is_lw || is_s || is_lui || is_jalr);
   assign sext_op  = !dv ? 3'd0 : (is_i || is_lw || is_jalr) ? EXT_I : is_s ? EXT_S :
                     is_b ? EXT_B : is_lui ? EXT_U : is_jal ? EXT_J : 3'd0;
   assign wd_sel   = !dv ? RF_ALU_C : is_lw ? RF_DRAM_RD : (is_jal || is_jalr) ? RF_NPC_PC4 : RF_ALU_C;
   assign pc_sel   = dv && is_jalr;
   assign npc_op   = dv && (is_jal || (is_b && taken));

   // run holds every strobe low for the first cycle after reset release.
   assign imem_req = run && st == S_IF;
   assign ir_we    = imem_req && imem_ack;
   assign dmem_req = st == S_MEM;
   assign dram_we  = st == S_MEM && is_s;
   assign pc_we    = (st == S_EX && is_b) || (st == S_MEM && is_s && dmem_ack) || st == S_WB;
   assign rf_we    = st == S_WB;
   assign halted   = st == S_HALT;
   assign state    = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= S_IF;
         run     <= 1'b0;
         instret <= 32'd0;
      end else begin
         run <= 1'b1;
         if (pc_we) instret <= instret + 32'd1;
         case (st)
            S_IF:    if (ir_we) st <= S_ID;
            S_ID:    st <= legal ? S_EX : S_HALT;
            S_EX:    st <= is_b ? S_IF : (is_lw || is_s) ? S_MEM : S_WB;
            S_MEM:   if (dmem_ack) st <= is_s ? S_IF : S_WB;
            S_WB:    st <= S_IF;
            S_HALT:  st <= S_HALT;
            default: st <= S_IF;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: table-driven, scoreboarded bench for the mc_cu control FSM.
module tb_mc_cu;
   localparam logic [1:0] EQ = 2'd0, LT = 2'd1, GT = 2'd2;

   logic        clk, rst_n, imem_ack, dmem_ack;
   logic [31:0] inst;
   logic [1:0]  branch;
   logic        imem_req, dmem_req, ir_we, pc_we, pc_sel, npc_op, rf_we, alub_sel, dram_we, halted;
   logic [1:0]  wd_sel;
   logic [2:0]  sext_op, state;
   logic [3:0]  alu_op;
   logic [31:0] instret;

   mc_cu dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .branch(branch),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .npc_op(npc_op), .rf_we(rf_we),
      .wd_sel(wd_sel), .sext_op(sext_op), .alu_op(alu_op), .alub_sel(alub_sel),
      .dram_we(dram_we), .state(state), .halted(halted), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [1:0]  br;
      int          dwait;
      int          cyc;
      int          rf;
      int          dw;
      int          dreq;
      logic        npc;
      logic        pcsel;
      logic [1:0]  wd;
      logic [2:0]  sext;
      logic [3:0]  alu;
      logic        alub;
   } vec_t;

   vec_t        tbl[$];
   vec_t        sbq[$];
   int          n_pass = 0, n_tot = 0;
   logic [31:0] exp_instret = 0;

   function automatic vec_t v(logic [31:0] i, logic [1:0] b, int dwt, int c, int rf, int dwe, int dr,
                              logic np, logic ps, logic [1:0] wd, logic [2:0] sx, logic [3:0] al, logic ab);
      vec_t r;
      r.inst = i; r.br = b; r.dwait = dwt; r.cyc = c; r.rf = rf; r.dw = dwe; r.dreq = dr;
      r.npc = np; r.pcsel = ps; r.wd = wd; r.sext = sx; r.alu = al; r.alub = ab;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic exec(input logic [31:0] i_inst, input logic [1:0] i_br, input int dwait);
      vec_t e;
      int   cyc = 0, npw = 0, nrf = 0, ndw = 0, ndr = 0, nir = 0, mc = 0;
      logic npc = 0, pcs = 0;
      bit   done = 0;
      e = sbq[0];
      inst = i_inst;
      branch = i_br;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         imem_ack = 1'b1;
         dmem_ack = (state == 3'd3) ? (mc >= dwait) : 1'b1;
         if (state == 3'd3) mc++;
         #1;
         if (k == 0) chk($sformatf("if_start %h", i_inst), state, 0);
         cyc++;
         npw += pc_we; nrf += rf_we; ndw += dram_we; ndr += dmem_req; nir += ir_we;
         if (state == 3'd1) begin
            chk($sformatf("alu_op %h", i_inst), alu_op, e.alu);
            chk($sformatf("alub_sel %h", i_inst), alub_sel, e.alub);
            chk($sformatf("sext_op %h", i_inst), sext_op, e.sext);
            chk($sformatf("wd_sel %h", i_inst), wd_sel, e.wd);
         end
         if (pc_we) begin
            npc = npc_op;
            pcs = pc_sel;
            done = 1;
         end
      end
      if (!done) begin
         n_tot++;
         $display("FAIL timeout %h: no pc_we within 40 cycles", i_inst);
      end
      e = sbq.pop_front();
      exp_instret++;
      chk($sformatf("cycles %h", i_inst), cyc, e.cyc);
      chk($sformatf("pc_we_cnt %h", i_inst), npw, 1);
      chk($sformatf("ir_we_cnt %h", i_inst), nir, 1);
      chk($sformatf("rf_we_cnt %h", i_inst), nrf, e.rf);
      chk($sformatf("dram_we_cnt %h", i_inst), ndw, e.dw);
      chk($sformatf("dmem_req_cnt %h", i_inst), ndr, e.dreq);
      chk($sformatf("npc_op %h", i_inst), npc, e.npc);
      chk($sformatf("pc_sel %h", i_inst), pcs, e.pcsel);
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      #1;
      chk($sformatf("end_if %h", i_inst), state, 0);
      chk($sformatf("instret %h", i_inst), instret, exp_instret);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  bad;
      bit  hit;
      //            inst          br dw cyc rf dw dr np ps wd sx al ab
      tbl.push_back(v(32'h003100B3, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add
      tbl.push_back(v(32'h403100B3, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // sub
      tbl.push_back(v(32'h403150B3, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 0, 7, 0)); // sra
      tbl.push_back(v(32'h003170B3, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 0, 2, 0)); // and
      tbl.push_back(v(32'h003110B3, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 0, 5, 0)); // sll
      tbl.push_back(v(32'h40010093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 1)); // addi, bit30 set
      tbl.push_back(v(32'h40015093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 7, 1)); // srai
      tbl.push_back(v(32'h00015093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 6, 1)); // srli
      tbl.push_back(v(32'h00016093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 3, 1)); // ori
      tbl.push_back(v(32'h00014093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 4, 1)); // xori
      tbl.push_back(v(32'h00012093, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 1)); // slti -> add
      tbl.push_back(v(32'h00012083, EQ, 0, 5, 1, 0, 1, 0, 0, 1, 1, 0, 1)); // lw
      tbl.push_back(v(32'h00012083, EQ, 3, 8, 1, 0, 4, 0, 0, 1, 1, 0, 1)); // lw, 3 wait
      tbl.push_back(v(32'h00312023, EQ, 0, 4, 0, 1, 1, 0, 0, 0, 2, 0, 1)); // sw
      tbl.push_back(v(32'h00312023, EQ, 2, 6, 0, 3, 3, 0, 0, 0, 2, 0, 1)); // sw, 2 wait
      tbl.push_back(v(32'h00310063, EQ, 0, 3, 0, 0, 0, 1, 0, 0, 3, 1, 0)); // beq taken
      tbl.push_back(v(32'h00310063, LT, 0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0)); // beq not
      tbl.push_back(v(32'h00311063, LT, 0, 3, 0, 0, 0, 1, 0, 0, 3, 1, 0)); // bne taken
      tbl.push_back(v(32'h00311063, EQ, 0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0)); // bne not
      tbl.push_back(v(32'h00314063, LT, 0, 3, 0, 0, 0, 1, 0, 0, 3, 1, 0)); // blt taken
      tbl.push_back(v(32'h00314063, GT, 0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0)); // blt not
      tbl.push_back(v(32'h00315063, EQ, 0, 3, 0, 0, 0, 1, 0, 0, 3, 1, 0)); // bge eq
      tbl.push_back(v(32'h00315063, GT, 0, 3, 0, 0, 0, 1, 0, 0, 3, 1, 0)); // bge gt
      tbl.push_back(v(32'h00315063, LT, 0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0)); // bge not
      tbl.push_back(v(32'h00316063, LT, 0, 3, 0, 0, 0, 0, 0, 0, 3, 1, 0)); // bltu never
      tbl.push_back(v(32'h123450B7, EQ, 0, 4, 1, 0, 0, 0, 0, 0, 4, 8, 1)); // lui
      tbl.push_back(v(32'h000000EF, EQ, 0, 4, 1, 0, 0, 1, 0, 2, 5, 0, 0)); // jal
      tbl.push_back(v(32'h000100E7, EQ, 0, 4, 1, 0, 0, 0, 1, 2, 1, 0, 1)); // jalr

      rst_n = 1'b0; inst = 32'h0; branch = EQ; imem_ack = 1'b1; dmem_ack = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_halted", halted, 0);
      chk("rst_instret", instret, 0);
      imem_ack = 1'b0; dmem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_imem_req", imem_req, 1);

      foreach (tbl[j]) begin
         sbq.push_back(tbl[j]);
         exec(tbl[j].inst, tbl[j].br, tbl[j].dwait);
      end

      // Illegal opcode parks the FSM in HALT with every strobe low.
      inst = 32'h0000007F;
      hit = 0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(negedge clk);
         imem_ack = 1'b1; dmem_ack = 1'b1;
         #1;
         hit = state == 3'd5;
      end
      chk("halt_reached", state, 5);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (!halted || imem_req || pc_we || ir_we || rf_we || dmem_req || dram_we) bad++;
      end
      chk("halt_quiet_cycles", bad, 0);
      chk("halt_instret", instret, exp_instret);
      rst_n = 1'b0;
      #1;
      chk("halt_rst_state", state, 0);
      chk("halt_rst_instret", instret, 0);
      chk("halt_rst_halted", halted, 0);
      exp_instret = 0;
      @(negedge clk);
      imem_ack = 1'b0; dmem_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("restart_imem_req", imem_req, 1);

      sbq.push_back(tbl[0]);
      exec(tbl[0].inst, tbl[0].br, tbl[0].dwait);

      // Reset landing in the middle of a stalled load.
      inst = 32'h00012083;
      hit = 0;
      for (int k = 0; k < 10 && !hit; k++) begin
         @(negedge clk);
         imem_ack = 1'b1; dmem_ack = 1'b0;
         #1;
         hit = state == 3'd3 && dmem_req;
      end
      chk("mid_mem_reached", {state, dmem_req}, {3'd3, 1'b1});
      chk("mid_mem_instret", instret, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_rst_dmem_req", dmem_req, 0);
      chk("mid_mem_rst_state", state, 0);
      chk("mid_mem_rst_instret", instret, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
